// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word fetches to a 1-cycle-latency memory
// and buffers returned words in a 2-entry FIFO toward the core, with redirect flush.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, data0_q, data0_d;
  logic [31:0] pc1_q, pc1_d, data1_q, data1_d;

  logic       pop_w;
  logic       push_w;
  logic [2:0] occ_w;

  assign pop_w      = inst_valid & inst_ready;
  assign push_w     = inflight_q & ~redirect_valid;
  // Slots already committed after this cycle's pop; a new fetch needs one free.
  assign occ_w      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_w};
  assign mem_req    = ~reset & ~redirect_valid & (occ_w < 3'd2);
  assign mem_addr   = {fetch_pc_q[31:2], 2'b00};
  assign inst_valid = ~reset & (count_q != 2'd0) & ~redirect_valid;
  assign inst_data  = data0_q;
  assign inst_pc    = pc0_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    infl_pc_d  = infl_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    data0_d    = data0_q;
    pc1_d      = pc1_q;
    data1_d    = data1_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = mem_req;
      if (mem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        infl_pc_d  = mem_addr;
      end
      // Entry 0 is the head; it is left untouched when the FIFO drains so the
      // outputs keep their last values.
      case ({push_w, pop_w})
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) begin
            pc0_d   = infl_pc_q;
            data0_d = mem_rdata;
          end else begin
            pc1_d   = infl_pc_q;
            data1_d = mem_rdata;
          end
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd2) begin
            pc0_d   = pc1_q;
            data0_d = data1_q;
          end
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            pc0_d   = pc1_q;
            data0_d = data1_q;
            pc1_d   = infl_pc_q;
            data1_d = mem_rdata;
          end else begin
            pc0_d   = infl_pc_q;
            data0_d = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= 32'd0;
      count_q    <= 2'd0;
      pc0_q      <= 32'd0;
      data0_q    <= 32'd0;
      pc1_q      <= 32'd0;
      data1_q    <= 32'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      data0_q    <= data0_d;
      pc1_q      <= pc1_d;
      data1_q    <= data1_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_w && !pop_w && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized ready/redirect traffic,
// checked against a queue-based model of the fetch pipeline.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int n_assert = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  ent_t        got[$];
  ent_t        m_last;
  logic [31:0] m_fetch;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  int          cyc_n;
  int          first_vld;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs to the model mid-cycle, advance the model
  // through the edge, then present memory read data for the following cycle.
  task automatic cycle();
    ent_t        head;
    bit          pop;
    bit          req;
    int          occ;
    logic [31:0] addr;
    @(negedge clk);
    head = (mq.size() != 0) ? mq[0] : m_last;
    pop  = (mq.size() != 0) && !redirect_valid && inst_ready;
    occ  = mq.size() + int'(m_infl) - int'(pop);
    req  = !redirect_valid && (occ < 2);
    addr = {m_fetch[31:2], 2'b00};
    chk("mem_req", {31'd0, mem_req}, {31'd0, req});
    chk("mem_addr", mem_addr, addr);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0 && !redirect_valid});
    chk("inst_pc", inst_pc, head.pc);
    chk("inst_data", inst_data, head.data);
    if (inst_valid && inst_ready) got.push_back('{inst_pc, inst_data});
    if (inst_valid && first_vld < 0) first_vld = cyc_n;
    cyc_n++;
    if (mq.size() != 0) m_last = mq[0];
    if (redirect_valid) begin
      mq.delete();
      m_infl  = 1'b0;
      m_fetch = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{m_infl_pc, mem_rdata});
      if (req) begin
        m_infl    = 1'b1;
        m_infl_pc = addr;
        m_fetch   = m_fetch + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    mem_rdata = req ? (32'h1000_0000 | addr) : $urandom();
  endtask

  // Reset is raised between edges and the outputs are checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_rdata = $urandom();
    mq.delete();
    got.delete();
    m_last    = '0;
    m_fetch   = 32'h0000_0000;
    m_infl    = 1'b0;
    m_infl_pc = 32'd0;
    cyc_n     = 0;
    first_vld = -1;
  endtask

  initial begin
    // Basic fetch
    inst_ready = 1'b1;
    do_reset();
    repeat (6) cycle();
    chk("first_valid_cycle", first_vld, 2);
    chk("basic_count", got.size(), 4);
    for (int i = 0; i < 3; i++) begin
      chk("basic_pc", got[i].pc, 32'(4 * i));
      chk("basic_data", got[i].data, 32'h1000_0000 | 32'(4 * i));
    end

    // Backpressure then drain
    inst_ready = 1'b0;
    do_reset();
    repeat (6) cycle();
    #1;
    chk("bp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("bp_mem_addr", mem_addr, 32'h8);
    chk("bp_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("bp_order_pc", got[i].pc, 32'(4 * i));

    // Redirect while a fetch is in flight
    do_reset();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0033;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("rdi_mem_addr", mem_addr, 32'h30);
    chk("rdi_mem_req", {31'd0, mem_req}, 32'd1);
    repeat (5) cycle();
    chk("rdi_count", got.size(), 3);
    chk("rdi_pc0", got[0].pc, 32'h30);
    chk("rdi_data0", got[0].data, 32'h1000_0030);
    chk("rdi_pc1", got[1].pc, 32'h34);

    // Redirect with a full FIFO and the core ready
    inst_ready = 1'b0;
    do_reset();
    repeat (4) cycle();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    chk("rdf_inst_valid", {31'd0, inst_valid}, 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("rdf_empty_valid", {31'd0, inst_valid}, 32'd0);
    chk("rdf_no_pop", got.size(), 0);
    chk("rdf_mem_addr", mem_addr, 32'h100);
    repeat (4) cycle();

    // Wrap-around of the fetch address
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    got.delete();
    repeat (6) cycle();
    chk("wrap_pc0", got[0].pc, 32'hFFFF_FFFC);
    chk("wrap_pc1", got[1].pc, 32'h0000_0000);
    chk("wrap_pc2", got[2].pc, 32'h0000_0004);
    chk("wrap_data1", got[1].data, 32'h1000_0000);

    // Reset mid-operation: full FIFO, then with a fetch in flight
    inst_ready = 1'b0;
    repeat (5) cycle();
    do_reset();
    inst_ready = 1'b1;
    cycle();
    cycle();
    do_reset();
    repeat (4) cycle();
    chk("mrst_pc0", got[0].pc, 32'h0);
    chk("mrst_data0", got[0].data, 32'h1000_0000);

    // Randomized ready/redirect traffic
    for (int i = 0; i < 400; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        default: redirect_pc = $urandom();
      endcase
      cycle();
    end
    redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
